// File: rtl/dds_wave_core.sv
// One DDS channel: phase accumulator plus 2**WAVE_STORE waveform tables held in lane-banked RAM.
// Tables are streamed in 32-bit words in load mode; one sample per clk is played back otherwise.
module dds_wave_core #(
  parameter int unsigned VERTICAL_RESOLUTION = 8,
  parameter int unsigned HORIZON_RESOLUTION  = 12,
  parameter int unsigned ADDER_LOWBIT        = 20,
  parameter int unsigned WAVE_STORE          = 2
) (
  input  logic                                                          clk,
  input  logic                                                          DDS_SLAVE_RSTN_SYNC,
  input  logic [WAVE_STORE-1:0]                                         wave_sel,
  input  logic [(2**WAVE_STORE)*(HORIZON_RESOLUTION+ADDER_LOWBIT)-1:0]  freq_ctrl,
  input  logic [(2**WAVE_STORE)*HORIZON_RESOLUTION-1:0]                 phase_ctrl,
  input  logic                                                          wr_enable,
  input  logic                                                          wr_valid,
  input  logic [31:0]                                                   wr_data,
  output logic [VERTICAL_RESOLUTION-1:0]                                wave_out
);

  localparam int unsigned VR    = VERTICAL_RESOLUTION;
  localparam int unsigned HR    = HORIZON_RESOLUTION;
  localparam int unsigned AW    = HORIZON_RESOLUTION + ADDER_LOWBIT;
  localparam int unsigned WS    = WAVE_STORE;
  localparam int unsigned NT    = 2 ** WAVE_STORE;
  localparam int unsigned SPW   = 32 / VERTICAL_RESOLUTION;
  localparam int unsigned LS    = $clog2(SPW);
  localparam int unsigned LSW   = (LS > 0) ? LS : 1;
  localparam int unsigned WW    = WS + HR - LS;
  localparam int unsigned DEPTH = 2 ** WW;

  logic [AW-1:0]  freq_arr  [NT];
  logic [HR-1:0]  phase_arr [NT];

  for (genvar i = 0; i < NT; i++) begin : g_unpack
    assign freq_arr[i]  = freq_ctrl[i*AW +: AW];
    assign phase_arr[i] = phase_ctrl[i*HR +: HR];
  end

  logic [AW-1:0]  acc;
  logic [HR-1:0]  wr_ptr;
  logic           wr_enable_d;
  logic           rd_live_q;
  logic [LSW-1:0] lane_sel_q;

  logic [HR-1:0]  rd_addr_c;
  logic [HR-1:0]  ptr_base_c;
  logic           wr_fire_c;
  logic [WW-1:0]  rd_word_c;
  logic [WW-1:0]  wr_word_c;
  logic [LSW-1:0] lane_c;
  logic [VR-1:0]  lane_q [SPW];

  // Address generation; a load-mode rising edge rebases the write pointer to 0 in the same cycle.
  always_comb begin
    rd_addr_c  = acc[AW-1 -: HR] + phase_arr[wave_sel];
    ptr_base_c = (wr_enable && !wr_enable_d) ? '0 : wr_ptr;
    wr_fire_c  = wr_enable & wr_valid & DDS_SLAVE_RSTN_SYNC;
    rd_word_c  = {wave_sel, rd_addr_c[HR-1 -: (HR-LS)]};
    wr_word_c  = {wave_sel, ptr_base_c[HR-1 -: (HR-LS)]};
    lane_c     = LSW'(rd_addr_c & HR'(SPW - 1));
  end

  // One RAM bank per sample lane: a whole word writes all lanes, a read picks one lane.
  for (genvar k = 0; k < SPW; k++) begin : g_lane
    logic [VR-1:0] mem [DEPTH];
    logic [VR-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_fire_c) begin
        mem[wr_word_c] <= wr_data[k*VR +: VR];
      end
      rd_q <= mem[rd_word_c];
    end

    assign lane_q[k] = rd_q;
  end

  // Accumulator, write pointer and output stage. rd_live_q masks the first read after load/reset.
  always_ff @(posedge clk or negedge DDS_SLAVE_RSTN_SYNC) begin
    if (!DDS_SLAVE_RSTN_SYNC) begin
      acc         <= '0;
      wr_ptr      <= '0;
      wr_enable_d <= 1'b0;
      rd_live_q   <= 1'b0;
      lane_sel_q  <= '0;
      wave_out    <= '0;
    end else begin
      wr_enable_d <= wr_enable;
      rd_live_q   <= ~wr_enable;
      lane_sel_q  <= lane_c;
      if (wr_enable) begin
        acc    <= '0;
        wr_ptr <= wr_valid ? ptr_base_c + HR'(SPW) : ptr_base_c;
      end else begin
        acc    <= acc + freq_arr[wave_sel];
      end
      if (wr_enable || !rd_live_q) begin
        wave_out <= '0;
      end else begin
        wave_out <= lane_q[lane_sel_q];
      end
    end
  end

endmodule

// File: tb/tb_dds_wave_core.sv
// Scoreboard bench for dds_wave_core: a table/accumulator model predicts every wave_out sample.
module tb_dds_wave_core;

  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   sel;
  logic [127:0] freq_ctrl;
  logic [47:0]  phase_ctrl;
  logic         we;
  logic         vld;
  logic [31:0]  data;
  logic [7:0]   wave_out;

  int unsigned  freq_a  [4];
  int           phase_a [4];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      freq_ctrl[i*32 +: 32]  = freq_a[i];
      phase_ctrl[i*12 +: 12] = 12'(phase_a[i]);
    end
  end

  dds_wave_core dut (
    .clk                 (clk),
    .DDS_SLAVE_RSTN_SYNC (rstn),
    .wave_sel            (sel),
    .freq_ctrl           (freq_ctrl),
    .phase_ctrl          (phase_ctrl),
    .wr_enable           (we),
    .wr_valid            (vld),
    .wr_data             (data),
    .wave_out            (wave_out)
  );

  // Reference state: table contents (-1 = never written), phase, write pointer, pending sample.
  int          mem_m [4][4096];
  int unsigned acc_m;
  int          ptr_m;
  bit          we_prev_m;
  int          nxt_m;

  typedef struct {
    int exp;
    int tag;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int tag   = 0;

  function automatic void model_edge();
    int out;
    int base;
    if (!rstn) begin
      acc_m = 0; ptr_m = 0; we_prev_m = 0; nxt_m = 0; out = 0;
    end else begin
      out = we ? 0 : nxt_m;
      if (we) nxt_m = 0;
      else    nxt_m = mem_m[sel][((acc_m >> 20) + phase_a[sel]) % 4096];
      if (we) begin
        base = we_prev_m ? ptr_m : 0;
        if (vld) begin
          for (int k = 0; k < 4; k++) mem_m[sel][(base + k) % 4096] = int'(data[k*8 +: 8]);
          ptr_m = (base + 4) % 4096;
        end else begin
          ptr_m = base;
        end
        acc_m = 0;
      end else begin
        acc_m = acc_m + freq_a[sel];
      end
      we_prev_m = we;
    end
    exp_q.push_back('{out, tag});
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] word_of(input int mode, input int n);
    case (mode)
      0:       return {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
      1:       return 32'hA5A5_A5A5;
      default: return $urandom;
    endcase
  endfunction

  // Stream nwords into table s; mode 3 picks a fresh table for every word.
  task automatic load(input int s, input int nwords, input int mode, input int gap_pct);
    sel = 2'(s);
    we  = 1'b1;
    for (int n = 0; n < nwords; n++) begin
      if (mode == 3) sel = 2'($urandom);
      vld  = 1'b1;
      data = word_of(mode, n);
      step();
      vld = 1'b0;
      while (int'($urandom_range(99)) < gap_pct) begin
        data = $urandom;
        step();
      end
    end
    vld = 1'b0;
  endtask

  task automatic play(input int n);
    we = 1'b0;
    repeat (n) step();
  endtask

  task automatic set_rst(input logic v);
    @(negedge clk);
    #1;
    rstn = v;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.exp >= 0) begin
        n_vec++;
        if (wave_out !== 8'(e.exp)) begin
          n_err++;
          $display("FAIL wave_out t%0d: got %0d expected %0d at %0t", e.tag, wave_out, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r;
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 4096; a++) mem_m[t][a] = -1;
      freq_a[t]  = 0;
      phase_a[t] = 0;
    end
    acc_m = 0; ptr_m = 0; we_prev_m = 0; nxt_m = 0;
    rstn = 1'b0; sel = '0; we = 1'b0; vld = 1'b0; data = '0;

    // Reset held while every input toggles.
    tag = 1;
    repeat (10) begin
      sel = 2'($urandom); we = 1'($urandom); vld = 1'($urandom); data = $urandom;
      freq_a[$urandom_range(3)] = $urandom; phase_a[$urandom_range(3)] = $urandom_range(4095);
      step();
    end
    for (int t = 0; t < 4; t++) begin freq_a[t] = 0; phase_a[t] = 0; end
    sel = '0; we = 1'b0; vld = 1'b0;
    set_rst(1'b1);
    play(4);

    // Ramp load into table 0, then playback at one address per clk.
    tag = 2;
    load(0, 1024, 0, 0);
    freq_a[0] = 32'd1 << 20;
    play(600);

    // Phase offset, half rate, triple rate with wrap.
    tag = 3;
    phase_a[0] = 100;
    we = 1'b1; step(); step();
    play(40);
    freq_a[0] = 32'd1 << 19;
    play(100);
    freq_a[0] = 32'd3 << 20;
    play(1500);

    // Reset during playback, release with zero frequency: table 0 at the phase offset.
    tag = 1;
    set_rst(1'b0);
    step(); step();
    freq_a[0] = 0; phase_a[0] = 77;
    set_rst(1'b1);
    play(6);

    // Table switch during playback and back.
    tag = 4;
    load(1, 1024, 1, 0);
    sel = 2'd0; freq_a[0] = 32'd1 << 20; phase_a[0] = 0; freq_a[1] = 32'd5 << 20;
    play(50);
    sel = 2'd1; play(20);
    sel = 2'd0; play(50);

    // Write edges: 1025 words with gaps wrap onto addr 0..3; stray valids while playing.
    tag = 5;
    load(2, 1025, 2, 40);
    sel = 2'd2; freq_a[2] = 32'd1 << 20; phase_a[2] = 0;
    play(20);
    for (int i = 0; i < 30; i++) begin
      vld = 1'b1; data = $urandom; step();
    end
    vld = 1'b0;
    play(4100);

    // Reset mid-load after 10 words, then reload: tail of the first image survives.
    tag = 6;
    load(3, 1024, 2, 0);
    load(3, 10, 2, 0);
    set_rst(1'b0);
    step(); step();
    set_rst(1'b1);
    load(3, 5, 2, 0);
    sel = 2'd3; freq_a[3] = 32'd1 << 20; phase_a[3] = 0;
    play(4100);

    // Randomized mix of table switches, frequency/phase changes, short loads, stray valids.
    tag = 7;
    for (int c = 0; c < 3000; c++) begin
      we = 1'b0;
      r  = int'($urandom_range(99));
      if (r < 3)       sel = 2'($urandom);
      else if (r < 6)  freq_a[$urandom_range(3)] = $urandom_range(32'h0FFF_FFFF);
      else if (r < 8)  phase_a[$urandom_range(3)] = $urandom_range(4095);
      else if (r < 9)  load($urandom_range(3), $urandom_range(1, 8), 3, 30);
      we   = 1'b0;
      vld  = (r >= 95);
      data = $urandom;
      step();
    end
    vld = 1'b0;
    play(2);

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
